// File: rtl/vx_commit_collector.sv
// Commit collector: buffers commit packets in a 2-entry FIFO, drives register-file writeback, checks per-warp sop/eop sequencing.
// Retired-instruction / active-lane counters exist only when VX_COMMIT_COLLECTOR_PERF_EN is defined.
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef UUID_WIDTH
`define UUID_WIDTH 44
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif
`ifndef LOG2UP
`define LOG2UP(x) (((x) > 1) ? $clog2(x) : 1)
`endif

module vx_commit_collector #(
    parameter int NUM_LANES  = `NUM_THREADS,
    parameter int WARP_CNT   = `NUM_WARPS,
    parameter int PID_WIDTH  = `LOG2UP(`NUM_THREADS / NUM_LANES),
    localparam int WID_W     = `LOG2UP(WARP_CNT),
    localparam int WARP_SLOTS = 1 << WID_W,
    localparam int WDATA_W   = NUM_LANES * `XLEN,
    localparam int PKT_W     = `UUID_WIDTH + WID_W + NUM_LANES + `XLEN + 1 + `NR_BITS
                               + WDATA_W + PID_WIDTH + 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  commit_valid,
    input  logic [PKT_W-1:0]      commit_data,
    output logic                  commit_ready,
    output logic                  wb_valid,
    output logic [WID_W-1:0]      wb_wid,
    output logic [`NR_BITS-1:0]   wb_rd,
    output logic [NUM_LANES-1:0]  wb_tmask,
    output logic [WDATA_W-1:0]    wb_data,
    output logic [PID_WIDTH-1:0]  wb_pid,
    input  logic                  wb_ready,
    output logic                  seq_err,
    output logic [WID_W-1:0]      seq_err_wid,
    output logic [63:0]           perf_instr_cnt,
    output logic [63:0]           perf_lane_cnt
);

    typedef struct packed {
        logic [`UUID_WIDTH-1:0] uuid;
        logic [WID_W-1:0]       wid;
        logic [NUM_LANES-1:0]   tmask;
        logic [`XLEN-1:0]       pc;
        logic                   wb;
        logic [`NR_BITS-1:0]    rd;
        logic [WDATA_W-1:0]     data;
        logic [PID_WIDTH-1:0]   pid;
        logic                   sop;
        logic                   eop;
    } commit_pkt_t;

    typedef struct packed {
        logic [WID_W-1:0]       wid;
        logic [NUM_LANES-1:0]   tmask;
        logic                   wb;
        logic [`NR_BITS-1:0]    rd;
        logic [WDATA_W-1:0]     data;
        logic [PID_WIDTH-1:0]   pid;
    } fifo_entry_t;

    commit_pkt_t           in_pkt;
    fifo_entry_t           in_entry;
    fifo_entry_t           head;
    fifo_entry_t           mem_q [2];
    fifo_entry_t           mem_d [2];
    logic [1:0]            count_q, count_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [WARP_SLOTS-1:0] in_prog_q, in_prog_d;
    logic                  seq_err_q, seq_err_d;
    logic [WID_W-1:0]      seq_err_wid_q, seq_err_wid_d;
    logic                  head_valid;
    logic                  push;
    logic                  pop;
    logic                  seq_viol;
    logic                  unused_pkt_fields;

    assign in_pkt   = commit_data;
    assign in_entry = '{wid: in_pkt.wid, tmask: in_pkt.tmask, wb: in_pkt.wb,
                        rd: in_pkt.rd, data: in_pkt.data, pid: in_pkt.pid};
    assign unused_pkt_fields = ^{in_pkt.uuid, in_pkt.pc};

    // Ready depends only on registered occupancy (and reset), never on wb_ready.
    assign head_valid   = (count_q != 2'd0);
    assign head         = mem_q[rd_ptr_q];
    assign commit_ready = reset && (count_q != 2'd2);
    assign push         = commit_valid && commit_ready;
    assign pop          = head_valid && (!head.wb || wb_ready);

    assign wb_valid = reset && head_valid && head.wb;
    assign wb_wid   = head.wid;
    assign wb_rd    = head.rd;
    assign wb_tmask = head.tmask;
    assign wb_data  = head.data;
    assign wb_pid   = head.pid;

    always_comb begin
        count_d  = count_q + 2'(push) - 2'(pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_entry;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    // A new instruction must start on an idle warp; a continuation needs one in progress.
    assign seq_viol = in_pkt.sop ? in_prog_q[in_pkt.wid] : !in_prog_q[in_pkt.wid];

    always_comb begin
        in_prog_d     = in_prog_q;
        seq_err_d     = seq_err_q;
        seq_err_wid_d = seq_err_wid_q;
        if (push) begin
            in_prog_d[in_pkt.wid] = !in_pkt.eop;
            if (seq_viol && !seq_err_q) begin
                seq_err_d     = 1'b1;
                seq_err_wid_d = in_pkt.wid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q       <= 2'd0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            in_prog_q     <= '0;
            seq_err_q     <= 1'b0;
            seq_err_wid_q <= '0;
        end else begin
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            in_prog_q     <= in_prog_d;
            seq_err_q     <= seq_err_d;
            seq_err_wid_q <= seq_err_wid_d;
        end
    end

    // Payload storage carries no reset; occupancy alone qualifies it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    assign seq_err     = seq_err_q;
    assign seq_err_wid = seq_err_wid_q;

`ifdef VX_COMMIT_COLLECTOR_PERF_EN
    logic [63:0] perf_instr_q, perf_instr_d;
    logic [63:0] perf_lane_q, perf_lane_d;

    function automatic logic [63:0] lane_popcount(input logic [NUM_LANES-1:0] mask);
        logic [63:0] n;
        n = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            n = n + 64'(mask[i]);
        end
        return n;
    endfunction

    always_comb begin
        perf_instr_d = perf_instr_q;
        perf_lane_d  = perf_lane_q;
        if (push) begin
            if (in_pkt.eop) begin
                perf_instr_d = perf_instr_q + 64'd1;
            end
            perf_lane_d = perf_lane_q + lane_popcount(in_pkt.tmask);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_instr_q <= '0;
            perf_lane_q  <= '0;
        end else begin
            perf_instr_q <= perf_instr_d;
            perf_lane_q  <= perf_lane_d;
        end
    end

    assign perf_instr_cnt = perf_instr_q;
    assign perf_lane_cnt  = perf_lane_q;
`else
    assign perf_instr_cnt = '0;
    assign perf_lane_cnt  = '0;
`endif

endmodule
